clock_divisor_prog: RTL and testbench

- Parametrised successor to the fixed free-running divider: N_CH independent channels, each with a runtime-programmable divide ratio.
- Each channel produces a one-cycle tick (clock enable) and a near-50%-duty divided level.
- Sits beside the top-level clock logic. Feeds display/scan timing and slideshow-advance logic as enables on the single system clock; outputs are never used as clock-tree clocks.
- Ratio changes are glitch-free (applied only at period boundary); a global sync input phase-aligns all channels.

---
 rtl/clkdiv_pkg.sv | 13 +
 rtl/clkdiv_channel.sv | 79 +++++++
 rtl/clock_divisor_prog.sv | 46 ++++
 tb/tb_clock_divisor_prog.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the programmable multi-channel clock divider.
package clkdiv_pkg;

  localparam int unsigned CLKDIV_CNT_W       = 22;
  localparam int unsigned CLKDIV_DEFAULT_DIV = 3;
  // Extra bit on the half-point sum so (div_act + 2) cannot wrap at all-ones.
  localparam int unsigned CLKDIV_HALF_GUARD  = 1;

  function automatic int unsigned clkdiv_sel_w(input int unsigned n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, active/shadow divisor pair and registered
// tick / divided-level outputs.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int unsigned CNT_W       = CLKDIV_CNT_W,
  parameter int unsigned DEFAULT_DIV = CLKDIV_DEFAULT_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             sync,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             tick_o,
  output logic             clk_o,
  output logic             pend_o
);

  localparam int unsigned      HALF_W  = CNT_W + CLKDIV_HALF_GUARD;
  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_div_act;
  logic [CNT_W-1:0]  r_div_shd;
  logic              r_pend;
  logic              r_tick;
  logic              r_clk;
  logic              w_term;
  logic              w_xfer;
  logic              w_below_half;
  logic [HALF_W-1:0] w_half;

  always_comb begin
    w_term       = (r_cnt == r_div_act);
    w_half       = (HALF_W'(r_div_act) + HALF_W'(2)) >> 1;
    w_below_half = (HALF_W'(r_cnt) < w_half);
    // Period boundary: terminal count, idle channel, or global restart.
    w_xfer       = r_pend && (!en_i || sync || w_term);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_div_act <= DIV_RST;
      r_div_shd <= DIV_RST;
      r_pend    <= 1'b0;
      r_tick    <= 1'b0;
      r_clk     <= 1'b0;
    end else begin
      if (sync || !en_i) begin
        r_cnt  <= '0;
        r_tick <= 1'b0;
        r_clk  <= 1'b0;
      end else begin
        r_cnt  <= w_term ? '0 : r_cnt + CNT_W'(1);
        r_tick <= w_term;
        r_clk  <= w_below_half;
      end

      if (w_xfer) begin
        r_div_act <= r_div_shd;
      end

      // A write coinciding with a transfer keeps pend set so it applies next boundary.
      if (wr_i) begin
        r_div_shd <= cfg_div;
        r_pend    <= 1'b1;
      end else if (w_xfer) begin
        r_pend    <= 1'b0;
      end
    end
  end

  assign tick_o = r_tick;
  assign clk_o  = r_clk;
  assign pend_o = r_pend;

endmodule

// File: rtl/clock_divisor_prog.sv
// N_CH independent programmable dividers producing clock enables and divided
// levels on the system clock; cfg_ch selects which channel a write targets.
module clock_divisor_prog
  import clkdiv_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned CNT_W       = CLKDIV_CNT_W,
  parameter int unsigned DEFAULT_DIV = CLKDIV_DEFAULT_DIV
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N_CH-1:0]                 en,
  input  logic                            sync,
  input  logic                            cfg_we,
  input  logic [clkdiv_sel_w(N_CH)-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]                cfg_div,
  output logic [N_CH-1:0]                 tick,
  output logic [N_CH-1:0]                 clk_out,
  output logic [N_CH-1:0]                 pending
);

  localparam int unsigned CH_W = clkdiv_sel_w(N_CH);

  logic [N_CH-1:0] w_wr;

  // Out-of-range indices match no channel, so such writes are dropped.
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign w_wr[g] = cfg_we && (cfg_ch == CH_W'(g));

    clkdiv_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (en[g]),
      .sync    (sync),
      .wr_i    (w_wr[g]),
      .cfg_div (cfg_div),
      .tick_o  (tick[g]),
      .clk_o   (clk_out[g]),
      .pend_o  (pending[g])
    );
  end

endmodule

// File: tb/tb_clock_divisor_prog.sv
// Directed bench for clock_divisor_prog: expected outputs are queued as each
// step is driven and compared one cycle later against the DUT.
module tb_clock_divisor_prog;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  en = '0;
  logic        sync = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [21:0] cfg_div = '0;
  logic [3:0]  tick, clk_out, pending;

  logic [2:0]  en2 = '0;
  logic [1:0]  cfg_ch2 = 2'd3;
  logic [2:0]  tick2, clk_out2, pending2;

  always #5 clk = ~clk;

  clock_divisor_prog #(.N_CH(4), .CNT_W(22), .DEFAULT_DIV(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .tick(tick), .clk_out(clk_out), .pending(pending)
  );

  // Three channels, so index 3 is out of range and must never be written.
  clock_divisor_prog #(.N_CH(3), .CNT_W(22), .DEFAULT_DIV(3)) dut_oor (
    .clk(clk), .rst_n(rst_n), .en(en2), .sync(sync), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch2), .cfg_div(cfg_div),
    .tick(tick2), .clk_out(clk_out2), .pending(pending2)
  );

  typedef struct packed {
    logic [3:0] m;
    logic [3:0] t;
    logic [3:0] c;
    logic [3:0] p;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Returns {tick, clk_out} for the k-th edge (k>=1) after a restart with period p.
  function automatic logic [1:0] wave(input int p, input int k);
    int ph;
    ph = (k - 1) % p;
    return {ph == p - 1, ph < (p + 1) / 2};
  endfunction

  task automatic step(input string tag, input logic [3:0] m, input logic [3:0] t,
                      input logic [3:0] c, input logic [3:0] p);
    exp_t e;
    e.m = m; e.t = t; e.c = c; e.p = p;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk({tag, ".tick"}, tick & e.m, e.t & e.m);
    chk({tag, ".clk_out"}, clk_out & e.m, e.c & e.m);
    chk({tag, ".pending"}, pending & e.m, e.p & e.m);
    chk({tag, ".oor_pending"}, {1'b0, pending2}, 4'b0000);
    cfg_we = 1'b0;
    sync   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] w;
    logic [3:0] et, ec, ev;
    int P[4];
    int st[4];
    P = '{4, 6, 7, 10};
    st = '{1, 2, 3, 4};

    // Reset state
    #1;
    chk("rst.tick", tick, 4'b0000);
    chk("rst.clk_out", clk_out, 4'b0000);
    chk("rst.pending", pending, 4'b0000);

    // 1: default divisor on ch0 only
    #11;
    rst_n = 1'b1;
    en = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      w = wave(4, k);
      step("t1", 4'hF, {3'b000, w[1]}, {3'b000, w[0]}, 4'h0);
    end

    // 2: D=0 then D=4 on ch1
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 22'd0;
    step("t2.wr0", 4'b0010, 4'b0000, 4'b0000, 4'b0010);
    step("t2.xfer", 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    en = 4'b0011;
    for (int k = 1; k <= 4; k++) step("t2.d0", 4'b0010, 4'b0010, 4'b0010, 4'b0000);
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 22'd4;
    step("t2.wr4", 4'b0010, 4'b0010, 4'b0010, 4'b0010);
    step("t2.bnd", 4'b0010, 4'b0010, 4'b0010, 4'b0000);
    for (int k = 1; k <= 10; k++) begin
      w = wave(5, k);
      step("t2.d4", 4'b0010, {2'b00, w[1], 1'b0}, {2'b00, w[0], 1'b0}, 4'b0000);
    end

    // 3: glitch-free D=3 -> D=1 on ch0
    en = 4'b0010;
    step("t3.off", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    en = 4'b0011;
    step("t3.k1", 4'b0001, 4'b0000, 4'b0001, 4'b0000);
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 22'd1;
    step("t3.k2", 4'b0001, 4'b0000, 4'b0001, 4'b0001);
    step("t3.k3", 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    step("t3.k4", 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    for (int k = 1; k <= 6; k++) begin
      w = wave(2, k);
      step("t3.p2", 4'b0001, {3'b000, w[1]}, {3'b000, w[0]}, 4'b0000);
    end

    // 4: write D=5 at terminal while D=7 is pending
    en = 4'b0010;
    step("t4.off", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    en = 4'b0011;
    step("t4.k1", 4'b0001, 4'b0000, 4'b0001, 4'b0000);
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 22'd7;
    step("t4.w7", 4'b0001, 4'b0001, 4'b0000, 4'b0001);
    step("t4.k3", 4'b0001, 4'b0000, 4'b0001, 4'b0001);
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 22'd5;
    step("t4.w5", 4'b0001, 4'b0001, 4'b0000, 4'b0001);
    for (int k = 1; k <= 8; k++) begin
      w = wave(8, k);
      step("t4.p8", 4'b0001, {3'b000, w[1]}, {3'b000, w[0]}, {3'b000, k < 8});
    end
    for (int k = 1; k <= 6; k++) begin
      w = wave(6, k);
      step("t4.p6", 4'b0001, {3'b000, w[1]}, {3'b000, w[0]}, 4'b0000);
    end

    // 5: staggered channels, then sync realigns them
    en = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      cfg_we = 1'b1; cfg_ch = 2'(c); cfg_div = 22'(P[c] - 1);
      step("t5.cfg", 4'hF, 4'h0, 4'h0, 4'(1 << c));
    end
    step("t5.idle", 4'hF, 4'h0, 4'h0, 4'h0);
    for (int n = 1; n <= 10; n++) begin
      ev = '0; et = '0; ec = '0;
      for (int i = 0; i < 4; i++) begin
        if (n >= st[i]) begin
          ev[i] = 1'b1;
          w = wave(P[i], n - st[i] + 1);
          et[i] = w[1];
          ec[i] = w[0];
        end
      end
      en = ev;
      step("t5.run", 4'hF, et, ec, 4'h0);
    end
    sync = 1'b1;
    step("t5.sync", 4'hF, 4'h0, 4'h0, 4'h0);
    for (int k = 1; k <= 22; k++) begin
      for (int i = 0; i < 4; i++) begin
        w = wave(P[i], k);
        et[i] = w[1];
        ec[i] = w[0];
      end
      step("t5.align", 4'hF, et, ec, 4'h0);
    end

    // 6: async reset between edges, then defaults restored
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6.rst.tick", tick, 4'b0000);
    chk("t6.rst.clk_out", clk_out, 4'b0000);
    chk("t6.rst.pending", pending, 4'b0000);
    #2;
    rst_n = 1'b1;
    en = 4'hF;
    for (int k = 1; k <= 8; k++) begin
      w = wave(4, k);
      step("t6.dflt", 4'hF, {4{w[1]}}, {4{w[0]}}, 4'h0);
    end

    // Out-of-range channel index on the three-channel instance
    en = 4'h0;
    en2 = 3'b111;
    for (int k = 1; k <= 8; k++) begin
      cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 22'd0;
      step("t6.oor", 4'h0, 4'h0, 4'h0, 4'h0);
      w = wave(4, k);
      chk("t6.oor.tick", {1'b0, tick2}, {1'b0, {3{w[1]}}});
      chk("t6.oor.clk_out", {1'b0, clk_out2}, {1'b0, {3{w[0]}}});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
